// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU data port (master) and a memory responder (slave).
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        ack;
  logic        err;
  logic [15:0] rdata;
  logic        busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, err, rdata, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, err, rdata, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised 16-bit RAM window answering byte-addressed load/store requests
// with a req/ack handshake and a fixed number of wait states.
module mem_responder #(
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  mem_responder_if.slave   bus
);

  localparam int          WORDS     = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [ADDR_BITS-1:0]   idx_q, idx_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [ADDR_BITS:0]     dec;
  logic                   mem_we;

  logic [15:0]            mem_q [WORDS];

  // Returns {err, word index}; the offset wraps modulo 2**16 so addresses
  // below the base land far out of the window instead of aliasing into it.
  function automatic logic [ADDR_BITS:0] decode(input logic [15:0] a);
    logic [15:0] off;
    logic [14:0] woff;
    logic        oow;
    off  = a - BASE_ADDR;
    woff = off[15:1];
    oow  = 32'(woff) >= 32'(WORDS);
    return {a[0] | oow, woff[ADDR_BITS-1:0]};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    dec     = decode(bus.addr);
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          wdata_d = bus.wdata;
          err_d   = dec[ADDR_BITS];
          idx_d   = dec[ADDR_BITS-1:0];
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latched request copy; only control state needs a reset value.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    err_q   <= err_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // The write lands on the RESP-entry edge; with zero wait states that is the
  // capture edge itself, hence the _d copies of the request fields.
  assign mem_we = !rst && (state_q != S_RESP) && (state_d == S_RESP) && we_d && !err_d;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign bus.ack   = (state_q == S_RESP);
  assign bus.err   = bus.ack && err_q;
  assign bus.rdata = (bus.ack && !we_q && !err_q) ? mem_q[idx_q] : 16'h0000;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: a 2-wait-state instance at base 0 and a
// zero-wait instance at base 16'h1000, both checked against an array model.
module tb_mem_responder;

  localparam int          W2 = 2;
  localparam int          W0 = 0;
  localparam logic [15:0] B2 = 16'h0000;
  localparam logic [15:0] B0 = 16'h1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus2();
  mem_responder_if bus0();

  logic        sel;
  logic        req_s, we_s;
  logic [15:0] addr_s, wdata_s;

  assign bus2.req   = req_s & ~sel;
  assign bus0.req   = req_s & sel;
  assign bus2.we    = we_s;
  assign bus0.we    = we_s;
  assign bus2.addr  = addr_s;
  assign bus0.addr  = addr_s;
  assign bus2.wdata = wdata_s;
  assign bus0.wdata = wdata_s;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W2), .BASE_ADDR(B2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(W0), .BASE_ADDR(B0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  logic        ack_o, err_o, busy_o;
  logic [15:0] rdata_o;
  assign ack_o   = sel ? bus0.ack   : bus2.ack;
  assign err_o   = sel ? bus0.err   : bus2.err;
  assign busy_o  = sel ? bus0.busy  : bus2.busy;
  assign rdata_o = sel ? bus0.rdata : bus2.rdata;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] mref [2][256];
  bit          mval [2][256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the address rules, in plain integers.
  function automatic void model_dec(input bit s, input logic [15:0] a, output bit e, output int idx);
    int base, off;
    base = s ? int'(B0) : int'(B2);
    off  = (int'(a) - base) & 'hFFFF;
    e    = (a % 2 != 0) || (off / 2 >= 256);
    idx  = (off / 2) % 256;
  endfunction

  function automatic int exp_lat(input bit s);
    return (s ? W0 : W2) + 1;
  endfunction

  task automatic txn(input bit s, input bit w, input logic [15:0] a, input logic [15:0] d, input bit drop);
    bit e, got;
    int idx, n;
    int si;
    si = s ? 1 : 0;
    model_dec(s, a, e, idx);
    sel = s;
    @(posedge clk); #1;
    req_s = 1'b1; we_s = w; addr_s = a; wdata_s = d;
    @(posedge clk); #1;
    we_s = ~w; addr_s = 16'($urandom); wdata_s = 16'($urandom);
    if (drop) req_s = 1'b0;
    n = 0; got = 0;
    while (!got && n < 30) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_capture", busy_o, 1);
      if (ack_o) got = 1;
    end
    check("ack_seen", got, 1);
    check("latency", n, exp_lat(s));
    check("err", err_o, e);
    if (!w) begin
      if (e) check("rdata_on_err", rdata_o, 16'h0000);
      else if (mval[si][idx]) check("rdata", rdata_o, mref[si][idx]);
    end
    if (w && !e) begin
      mref[si][idx] = d;
      mval[si][idx] = 1'b1;
    end
    req_s = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", ack_o, 0);
    check("idle_after_resp", busy_o, 0);
  endtask

  task automatic rand_txn(input bit s);
    logic [15:0] base, a;
    int kind;
    base = s ? B0 : B2;
    kind = $urandom_range(0, 5);
    case (kind)
      0:       a = base + 16'(2 * $urandom_range(0, 31)) + 16'd1;
      1:       a = base + 16'h0200 + 16'(2 * $urandom_range(0, 1000));
      2:       a = base - 16'(2 * $urandom_range(1, 8));
      default: a = base + 16'(2 * $urandom_range(0, 31));
    endcase
    txn(s, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    bit got, quiet;
    int n;
    rst = 1'b1; sel = 1'b0;
    req_s = 1'b1; we_s = 1'b1; addr_s = 16'h0010; wdata_s = 16'h5A5A;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) mval[s][i] = 1'b0;

    // reset held together with req: nothing may be captured
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", bus2.ack, 0);
    check("rst_err", bus2.err, 0);
    check("rst_rdata", bus2.rdata, 16'h0000);
    check("rst_busy", bus2.busy, 0);
    check("rst_busy0", bus0.busy, 0);
    req_s = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_not_captured", bus2.busy, 0);

    // store / load
    txn(0, 1, 16'h0010, 16'hBEEF, 0);
    txn(0, 0, 16'h0010, 16'h0000, 0);

    // error cases
    txn(0, 1, 16'h0011, 16'h1234, 0);
    txn(0, 0, 16'h0200, 16'h0000, 0);
    txn(0, 0, 16'h0010, 16'h0000, 0);
    txn(0, 0, 16'hFFFE, 16'h0000, 0);

    // back-to-back loads with req held high
    for (int i = 0; i < 4; i++) txn(0, 1, 16'(2 * i), 16'($urandom), 0);
    sel = 1'b0;
    @(posedge clk); #1;
    req_s = 1'b1; we_s = 1'b0; addr_s = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n = 0; got = 0;
      while (!got && n < 30) begin
        @(negedge clk);
        n++;
        if (ack_o) got = 1;
      end
      check("b2b_ack_seen", got, 1);
      check("b2b_spacing", n, (i == 0) ? W2 + 2 : W2 + 2);
      check("b2b_err", err_o, 0);
      check("b2b_rdata", rdata_o, mref[0][i]);
      addr_s = 16'(2 * (i + 1));
    end
    req_s = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", busy_o, 0);

    // reset during WAIT discards the pending store
    txn(0, 1, 16'h0020, 16'h5555, 0);
    sel = 1'b0;
    @(posedge clk); #1;
    req_s = 1'b1; we_s = 1'b1; addr_s = 16'h0020; wdata_s = 16'hAAAA;
    @(posedge clk); #1;
    req_s = 1'b0;
    @(negedge clk);
    check("abort_busy_in_wait", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_cleared", busy_o, 0);
    check("abort_no_ack_now", ack_o, 0);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ack_o) quiet = 1'b0;
    end
    check("abort_no_ack_later", quiet, 1);
    txn(0, 0, 16'h0020, 16'h0000, 0);

    // zero-wait instance, including req dropped right after capture
    txn(1, 1, 16'h1010, 16'hC0DE, 1);
    txn(1, 0, 16'h1010, 16'h0000, 1);
    txn(1, 0, 16'h0FFE, 16'h0000, 0);
    txn(1, 0, 16'h1200, 16'h0000, 0);

    // randomised traffic on both instances
    for (int i = 0; i < 40; i++) rand_txn(0);
    for (int i = 0; i < 30; i++) rand_txn(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
